dmem_ctrl: RTL

Data-memory access controller between the pipelined RV32I core's MEM stage and a word-wide synchronous data RAM. It converts each byte, halfword or word load/store from the core into word accesses with byte enables. Misaligned accesses are split into two consecutive word accesses. Load data is shifted and sign- or zero-extended. The core is stalled until the response is delivered.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_align.sv | 35 +++
 rtl/dmem_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 encodings, FSM states and access-size helpers for dmem_ctrl
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;
  function automatic logic [2:0] size_of(input logic [2:0] f3);
    return f3[1:0] == 2'b00 ? 3'd1 : f3[1:0] == 2'b01 ? 3'd2 : 3'd4;
  endfunction
  function automatic logic f3_invalid(input logic we, input logic [2:0] f3);
    return f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 || (we && f3[2]);
  endfunction
endpackage

// File: rtl/dmem_align.sv
// dmem_align: lane masks and write-data shift for stores, extract and extend for loads
module dmem_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] word1,
  input  logic [31:0] word2,
  output logic [3:0]  mask1,
  output logic [3:0]  mask2,
  output logic        split,
  output logic [63:0] wshift,
  output logic [31:0] rdata
);
  logic [2:0]  n;
  logic [7:0]  mask8;
  logic [63:0] rsh;
  // store side kept apart from load side: split selects the load words upstream
  always_comb begin
    n = size_of(funct3);
    mask8 = (n == 3'd1 ? 8'h01 : n == 3'd2 ? 8'h03 : 8'h0F) << off;
    mask1 = mask8[3:0];
    mask2 = mask8[7:4];
    split = |mask8[7:4];
    wshift = {32'b0, wdata} << {off, 3'b000};
  end
  always_comb begin
    rsh = {word2, word1} >> {off, 3'b000};
    rdata = funct3 == F3_B  ? {{24{rsh[7]}}, rsh[7:0]} :
            funct3 == F3_BU ? {24'b0, rsh[7:0]} :
            funct3 == F3_H  ? {{16{rsh[15]}}, rsh[15:0]} :
            funct3 == F3_HU ? {16'b0, rsh[15:0]} : rsh[31:0];
  end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: splits core byte/half/word loads and stores into word RAM accesses and stalls until done
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  state_t            state, state_n;
  logic              we_r;
  logic [2:0]        f3_r;
  logic [ADDR_W+1:0] addr_r;
  logic [31:0]       wdata_r, w1_r;
  logic              idle, split, unused;
  logic [3:0]        mask1, mask2;
  logic [63:0]       wshift;
  logic [31:0]       a_rdata;
  logic              mem_en_n;
  logic [3:0]        mem_we_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [31:0]       mem_wdata_n;
  assign unused = ^req_addr[31:ADDR_W+2];
  assign idle = state == IDLE;
  // in IDLE the aligner sees the live request so the first access can be registered on entry to ACC1
  dmem_align u_align (
    .funct3 (idle ? req_funct3 : f3_r),
    .off    (idle ? req_addr[1:0] : addr_r[1:0]),
    .wdata  (idle ? req_wdata : wdata_r),
    .word1  (split ? w1_r : mem_rdata),
    .word2  (split ? mem_rdata : 32'b0),
    .mask1  (mask1),
    .mask2  (mask2),
    .split  (split),
    .wshift (wshift),
    .rdata  (a_rdata)
  );
  always_comb begin
    state_n = state;
    mem_en_n = 1'b0;
    mem_we_n = '0;
    mem_addr_n = '0;
    mem_wdata_n = '0;
    case (state)
      IDLE: if (req_valid) begin
        if (f3_invalid(req_we, req_funct3)) state_n = RESP;
        else begin
          state_n = ACC1;
          mem_en_n = 1'b1;
          mem_we_n = req_we ? mask1 : 4'b0;
          mem_addr_n = req_addr[ADDR_W+1:2];
          mem_wdata_n = req_we ? wshift[31:0] : 32'b0;
        end
      end
      ACC1: if (split) begin
        state_n = ACC2;
        mem_en_n = 1'b1;
        mem_we_n = we_r ? mask2 : 4'b0;
        mem_addr_n = addr_r[ADDR_W+1:2] + ADDR_W'(1);
        mem_wdata_n = we_r ? wshift[63:32] : 32'b0;
      end else state_n = RESP;
      ACC2: state_n = RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      we_r <= 1'b0;
      f3_r <= '0;
      addr_r <= '0;
      wdata_r <= '0;
      w1_r <= '0;
      mem_en <= 1'b0;
      mem_we <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_n;
      if (idle && req_valid) begin
        we_r <= req_we;
        f3_r <= req_funct3;
        addr_r <= req_addr[ADDR_W+1:0];
        wdata_r <= req_wdata;
      end
      if (state == ACC2) w1_r <= mem_rdata;
      mem_en <= mem_en_n;
      mem_we <= mem_we_n;
      mem_addr <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
    end
  end
  assign stall = req_valid & (state != RESP);
  assign rsp_valid = state == RESP;
  assign rsp_err = rsp_valid & f3_invalid(we_r, f3_r);
  assign rsp_rdata = rsp_valid && !we_r && !rsp_err ? a_rdata : 32'b0;
endmodule
